// File: rtl/mdu_div.sv
// ============================================================================
// Module      : mdu_div
// Description : Multi-cycle restoring radix-2 divider (DIV/DIVU), result is
//               {remainder, quotient}, with annul and divide-by-zero handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int               C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [C_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_divisor;
    logic                 r_neg_a;
    logic                 r_neg_b;
    logic                 r_ready;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_go;
    logic                 w_last;
    logic                 w_dvd_neg;
    logic                 w_dvs_neg;
    logic [WIDTH-1:0]     w_dvd_abs;
    logic [WIDTH-1:0]     w_dvs_abs;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [WIDTH-1:0]     w_quo_nx;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_go      = start_i & ~annul_i;
    assign w_last    = (r_count == C_LAST);
    assign w_dvd_neg = signed_i & dividend_i[WIDTH-1];
    assign w_dvs_neg = signed_i & divisor_i[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -dividend_i : dividend_i;
    assign w_dvs_abs = w_dvs_neg ? -divisor_i : divisor_i;

    // One restoring step: bring in the next dividend bit, keep the trial
    // difference only when it did not go negative.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_divisor};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_fix = (r_neg_a ^ r_neg_b) ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = r_neg_a ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_next_state = (divisor_i == '0) ? DIVZERO : ON;
                end
            end
            DIVZERO: w_next_state = END;
            ON: begin
                if (!w_go) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = END;
                end
            end
            END: begin
                if (!w_go) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_count   <= '0;
                        r_quo     <= w_dvd_abs;
                        r_rem     <= '0;
                        r_divisor <= w_dvs_abs;
                        r_neg_a   <= w_dvd_neg;
                        r_neg_b   <= w_dvs_neg;
                    end
                end
                DIVZERO: begin
                    r_quo <= '0;
                    r_rem <= '0;
                end
                ON: begin
                    if (!w_go) begin
                        r_count <= '0;
                        r_quo   <= '0;
                        r_rem   <= '0;
                    end else if (w_last) begin
                        r_count <= '0;
                        r_quo   <= w_quo_fix;
                        r_rem   <= w_rem_fix;
                    end else begin
                        r_count <= r_count + 1'b1;
                        r_quo   <= w_quo_nx;
                        r_rem   <= w_rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: visible from the second END cycle, dropped on the same
    // edge that leaves END, so ready_o is only ever high while in END.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_ready  <= (r_state == END) && w_go;
            r_result <= ((r_state == END) && w_go) ? {r_rem, r_quo} : '0;
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule

`default_nettype wire
